multi_bldc_commutator: RTL and testbench
========================================

MULTI_BLDC_COMMUTATOR -- requirements
Module: multi_bldc_commutator

Interface
REQ-001 SHALL have parameter N_MOTORS, default 4, number of motor channels (1..16).
REQ-002 SHALL have parameter DEADTIME_CYC, default 8, all-off clock cycles inserted on every drive-pattern change (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd  input  8  command byte from the UART receiver.
REQ-006 SHALL have port cmd_valid  input  1  one-cycle strobe qualifying cmd.
REQ-007 SHALL have port hs  input  3*N_MOTORS  hall sensors; channel k at [3k+2:3k], bit order {C,B,A}, asynchronous to clk.
REQ-008 SHALL have port pt  output  6*N_MOTORS  power-transistor gates; channel k at [6k+5:6k] = {AH,BH,CH,AL,BL,CL}, active-high.
REQ-009 SHALL have port fault  output  N_MOTORS  sticky per-channel hall-fault flag.
REQ-010 SHALL have port cmd_err  output  1  one-cycle pulse on a rejected command.

Function
REQ-011 SHALL decode cmd as: [7:4] channel index, [3] broadcast, [2] enable, [1] direction (1=forward), [0] brake.
REQ-012 SHALL, on cmd_valid with broadcast=1, load {enable,direction,brake} into every channel's control register the next cycle.
REQ-013 SHALL, on cmd_valid with broadcast=0 and index < N_MOTORS, load only that channel's control register the next cycle.
REQ-014 SHALL, on cmd_valid with broadcast=0 and index >= N_MOTORS, change no state and assert cmd_err for exactly one cycle, one cycle after the strobe.
REQ-015 SHALL pass each hall input through a two-flop synchroniser before use.
REQ-016 SHALL compute the target pattern per channel with priority: fault -> all off; enable=0 -> all off; brake=1 -> {000,111}; otherwise six-step table.
REQ-017 SHALL use forward table (hall -> pt): 101->100_010, 100->100_001, 110->010_001, 010->010_100, 011->001_100, 001->001_010.
REQ-018 SHALL use, for direction=0, the forward entry with the high-side and low-side halves swapped.
REQ-019 SHALL set fault[k] when synchronised hall code of channel k is 000 or 111 for 2 consecutive cycles; pt for k goes all-off the cycle after fault sets, with no dead-time.
REQ-020 SHALL clear fault[k] only on an accepted command addressing k (incl. broadcast) with enable=0.
REQ-021 SHALL, when a channel's target differs from its applied pattern, drive all-off for DEADTIME_CYC cycles, then apply the target current at expiry.
REQ-022 SHALL restart the dead-time counter if the target changes again during dead-time.
REQ-023 SHALL apply transitions to all-off (disable, fault) immediately, without dead-time.
REQ-024 SHALL never assert both high and low side of the same phase in any cycle.
REQ-025 SHALL have latency hall edge -> pt all-off of 3 cycles and -> new pattern of 3+DEADTIME_CYC cycles.
REQ-026 SHALL register pt, fault and cmd_err (no combinational path from inputs).

Reset
REQ-027 SHALL, while rst=1, force pt=0, fault=0, cmd_err=0, all control registers {enable=0,direction=1,brake=0}, synchronisers=0, dead-time counters=0.
REQ-028 SHALL, after rst deassertion mid-operation, keep all channels off until a new enable command is accepted.

Structure
REQ-029 SHALL place command field bit positions, pattern width constant and the forward commutation table in shared package bldc_pkg.
REQ-030 SHALL instantiate N_MOTORS copies of sub-module bldc_channel (synchroniser, fault detect, table, dead-time counter, control register); top holds command decode only.

Verification
REQ-031 SHALL cover: N=4, DT=8, cmd=0x06 (ch0 enable fwd), hs0=101 -> pt[5:0]=100_010 at cycle 11 after hall settles, 000000 before.
REQ-032 SHALL cover: running ch0, hs0 101->100 -> pt[5:0]=000000 for 8 cycles, then 100_001; hall toggled back within dead-time restarts count.
REQ-033 SHALL cover: cmd=0x0C (broadcast enable reverse), hs1=101 -> pt[11:6]=010_100; cmd=0x0D -> all channels 000_111 after 8 all-off cycles.
REQ-034 SHALL cover: hs2=111 held -> fault[2]=1, pt[17:12]=0 immediately; cmd=0x26 leaves fault set; cmd=0x20 clears it.
REQ-035 SHALL cover: cmd=0x56 with N=4 -> cmd_err single pulse, no pt change; rst asserted mid-dead-time -> pt=0 asynchronously, stays 0 after release.

Source files
------------

// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared command fields, pattern width and commutation table
//
// Purpose : constants and types shared by the commutator top, its command
//           interface and every channel instance.
// Contents: command byte bit positions, drive-pattern width/type, channel
//           control register type and reset value, brake pattern, and the
//           forward six-step table (hall {C,B,A} -> {AH,BH,CH,AL,BL,CL}).
package bldc_pkg;

    localparam int cmd_w      = 8;
    localparam int cmd_idx_hi = 7;
    localparam int cmd_idx_lo = 4;
    localparam int cmd_bcast  = 3;
    localparam int cmd_en     = 2;
    localparam int cmd_dir    = 1;
    localparam int cmd_brk    = 0;

    localparam int pat_w = 6;
    typedef logic [pat_w-1:0] pat_t;

    typedef struct packed {
        logic en;
        logic dir;
        logic brk;
    } ctrl_t;

    localparam ctrl_t ctrl_rst  = '{en: 1'b0, dir: 1'b1, brk: 1'b0};
    localparam pat_t  brake_pat = 6'b000_111;

    // Forward rotation; illegal hall codes (000/111) map to all-off.
    function automatic pat_t fwd_table(input logic [2:0] hall);
        case (hall)
            3'b101:  fwd_table = 6'b100_010;
            3'b100:  fwd_table = 6'b100_001;
            3'b110:  fwd_table = 6'b010_001;
            3'b010:  fwd_table = 6'b010_100;
            3'b011:  fwd_table = 6'b001_100;
            3'b001:  fwd_table = 6'b001_010;
            default: fwd_table = 6'b000_000;
        endcase
    endfunction

endpackage

// File: rtl/multi_bldc_commutator_if.sv
// rtl/multi_bldc_commutator_if.sv - command bus between UART receiver and commutator
//
// Purpose : groups the command byte, its strobe and the reject pulse.
// Signals : cmd[7:0]  command byte {index[3:0], broadcast, enable, direction, brake}
//           cmd_valid one-cycle strobe qualifying cmd
//           cmd_err   one-cycle pulse when a command addresses a missing channel
// Modports: master (command source), slave (commutator).
interface multi_bldc_commutator_if;
    import bldc_pkg::*;

    logic [cmd_w-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_err;

    modport master (output cmd, output cmd_valid, input cmd_err);
    modport slave  (input cmd, input cmd_valid, output cmd_err);

endinterface

// File: rtl/bldc_channel.sv
// rtl/bldc_channel.sv - one motor channel: hall sync, fault, table, dead-time, control
//
// Purpose : turns one motor's hall code and control register into a
//           registered gate pattern with break-before-make dead-time.
// Ports   : clk, rst     clock, asynchronous active-high reset
//           hs[2:0]      raw hall inputs {C,B,A}, asynchronous to clk
//           ld           load ctrl_in into the control register this edge
//           ctrl_in      {enable, direction, brake} from the command decoder
//           pt[5:0]      registered gates {AH,BH,CH,AL,BL,CL}
//           fault        sticky illegal-hall flag
module bldc_channel
    import bldc_pkg::*;
#(
    parameter int DEADTIME_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hs,
    input  logic       ld,
    input  ctrl_t      ctrl_in,
    output pat_t       pt,
    output logic       fault
);

    localparam logic [7:0] dt_load = 8'(DEADTIME_CYC);

    logic [2:0] hs_s1;
    logic [2:0] hs_s2;
    logic       bad_q;
    logic       hall_bad;
    ctrl_t      ctrl;
    pat_t       fwd_pat;
    pat_t       target;
    pat_t       cur_tgt;
    logic [7:0] dt_cnt;

    assign hall_bad = (hs_s2 == 3'b000) || (hs_s2 == 3'b111);

    always_comb begin
        fwd_pat = fwd_table(hs_s2);
        if (fault || !ctrl.en) begin
            target = '0;
        end else if (ctrl.brk) begin
            target = brake_pat;
        end else if (ctrl.dir) begin
            target = fwd_pat;
        end else begin
            // Reverse rotation drives the same phases with high/low swapped.
            target = {fwd_pat[2:0], fwd_pat[5:3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1   <= 3'b000;
            hs_s2   <= 3'b000;
            bad_q   <= 1'b0;
            ctrl    <= ctrl_rst;
            fault   <= 1'b0;
            cur_tgt <= '0;
            dt_cnt  <= 8'd0;
            pt      <= '0;
        end else begin
            hs_s1 <= hs;
            hs_s2 <= hs_s1;
            bad_q <= hall_bad;

            if (ld) begin
                ctrl <= ctrl_in;
            end

            // A disabling command clears the flag; if the hall is still bad
            // the flag re-arms after two more bad samples.
            if (ld && !ctrl_in.en) begin
                fault <= 1'b0;
            end else if (hall_bad && bad_q) begin
                fault <= 1'b1;
            end

            if (target == '0) begin
                // Turning off never needs dead-time.
                pt      <= '0;
                cur_tgt <= '0;
                dt_cnt  <= 8'd0;
            end else if (target != cur_tgt) begin
                // New pattern (or change during dead-time): off and restart.
                pt      <= '0;
                cur_tgt <= target;
                dt_cnt  <= dt_load;
            end else if (dt_cnt != 8'd0) begin
                if (dt_cnt == 8'd1) begin
                    pt <= cur_tgt;
                end
                dt_cnt <= dt_cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/multi_bldc_commutator.sv
// rtl/multi_bldc_commutator.sv - multi-channel BLDC six-step commutator
//
// Purpose : decodes command bytes into per-channel control loads and
//           instantiates one bldc_channel per motor.
// Ports   : clk, rst     clock, asynchronous active-high reset
//           bus          command bus (slave): cmd, cmd_valid in; cmd_err out
//           hs           hall inputs, channel k at [3k+2:3k] = {C,B,A}
//           pt           gate outputs, channel k at [6k+5:6k] = {AH,BH,CH,AL,BL,CL}
//           fault        sticky per-channel hall fault
module multi_bldc_commutator
    import bldc_pkg::*;
#(
    parameter int N_MOTORS     = 4,
    parameter int DEADTIME_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_bldc_commutator_if.slave  bus,
    input  logic [3*N_MOTORS-1:0]   hs,
    output logic [6*N_MOTORS-1:0]   pt,
    output logic [N_MOTORS-1:0]     fault
);

    localparam logic [4:0] n_lim = 5'(N_MOTORS);

    logic [3:0] idx;
    logic       bcast;
    logic       bad_idx;
    ctrl_t      cmd_ctrl;
    logic       cmd_err_q;

    assign idx      = bus.cmd[cmd_idx_hi:cmd_idx_lo];
    assign bcast    = bus.cmd[cmd_bcast];
    assign bad_idx  = !bcast && ({1'b0, idx} >= n_lim);
    assign cmd_ctrl = '{en: bus.cmd[cmd_en], dir: bus.cmd[cmd_dir], brk: bus.cmd[cmd_brk]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= bus.cmd_valid && bad_idx;
        end
    end

    assign bus.cmd_err = cmd_err_q;

    for (genvar k = 0; k < N_MOTORS; k++) begin : g_ch
        logic ld;
        assign ld = bus.cmd_valid && (bcast || (idx == 4'(k)));

        bldc_channel #(
            .DEADTIME_CYC(DEADTIME_CYC)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .hs      (hs[3*k +: 3]),
            .ld      (ld),
            .ctrl_in (cmd_ctrl),
            .pt      (pt[6*k +: 6]),
            .fault   (fault[k])
        );
    end

endmodule

// File: tb/tb_multi_bldc_commutator.sv
// tb/tb_multi_bldc_commutator.sv - self-checking bench for multi_bldc_commutator
module tb_multi_bldc_commutator;

    localparam int N  = 4;
    localparam int DT = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3*N-1:0] hs;
    logic [6*N-1:0] pt;
    logic [N-1:0]   fault;

    multi_bldc_commutator_if bus ();

    multi_bldc_commutator #(.N_MOTORS(N), .DEADTIME_CYC(DT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .hs    (hs),
        .pt    (pt),
        .fault (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_en    [N];
    logic       m_dir   [N];
    logic       m_brk   [N];
    logic       m_fault [N];
    logic [2:0] m_h1    [N];
    logic [2:0] m_h2    [N];
    int         m_bad_run [N];
    int         m_run   [N];
    logic [5:0] m_last  [N];
    logic [5:0] m_pt    [N];
    logic       m_err;

    function automatic logic [5:0] fwd_pat(input logic [2:0] h);
        case (h)
            3'd5:    return 6'b100010;
            3'd4:    return 6'b100001;
            3'd6:    return 6'b010001;
            3'd2:    return 6'b010100;
            3'd3:    return 6'b001100;
            3'd1:    return 6'b001010;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] tgt_of(input int k);
        logic [5:0] f;
        f = fwd_pat(m_h2[k]);
        if (m_fault[k] || !m_en[k]) return 6'd0;
        if (m_brk[k]) return 6'b000111;
        return m_dir[k] ? f : {f[2:0], f[5:3]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_en[k] = 1'b0; m_dir[k] = 1'b1; m_brk[k] = 1'b0; m_fault[k] = 1'b0;
            m_h1[k] = 3'd0; m_h2[k] = 3'd0; m_bad_run[k] = 0; m_run[k] = 0;
            m_last[k] = 6'd0; m_pt[k] = 6'd0;
        end
        m_err = 1'b0;
    endtask

    // Advances the model over one rising edge using the inputs now applied.
    // A pattern is on the gates once the target has been the same nonzero
    // value for DT+1 consecutive edges; otherwise the gates are off.
    task automatic model_edge();
        logic [5:0] t;
        logic [2:0] seen;
        logic       addr;
        int         idx;
        idx = int'(bus.cmd[7:4]);
        for (int k = 0; k < N; k++) begin
            seen = m_h2[k];
            t    = tgt_of(k);
            if (seen == 3'b000 || seen == 3'b111) m_bad_run[k]++; else m_bad_run[k] = 0;
            if (m_run[k] > 0 && t == m_last[k]) m_run[k]++; else m_run[k] = 1;
            m_last[k] = t;
            m_pt[k]   = (t != 6'd0 && m_run[k] >= DT + 1) ? t : 6'd0;
            m_h2[k]   = m_h1[k];
            m_h1[k]   = hs[3*k +: 3];
            addr = bus.cmd_valid && (bus.cmd[3] || idx == k);
            if (addr && !bus.cmd[2]) m_fault[k] = 1'b0;
            else if (m_bad_run[k] >= 2) m_fault[k] = 1'b1;
            if (addr) begin
                m_en[k] = bus.cmd[2]; m_dir[k] = bus.cmd[1]; m_brk[k] = bus.cmd[0];
            end
        end
        m_err = bus.cmd_valid && !bus.cmd[3] && idx >= N;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("pt[%0d]", k), 32'(pt[6*k +: 6]), 32'(m_pt[k]));
            chk($sformatf("fault[%0d]", k), 32'(fault[k]), 32'(m_fault[k]));
            chk($sformatf("shoot[%0d]", k), 32'(pt[6*k+3 +: 3] & pt[6*k +: 3]), 32'd0);
        end
        chk("cmd_err", 32'(bus.cmd_err), 32'(m_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] c);
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic set_hall(input int k, input logic [2:0] v);
        hs[3*k +: 3] = v;
    endtask

    // Steps until channel k shows a nonzero pattern after at least one off cycle.
    task automatic wait_pattern(input int k, input int maxc, output int cyc,
                                output int zc, output logic [5:0] val);
        bit zero_seen;
        zero_seen = 1'b0;
        cyc = -1; zc = 0; val = 6'd0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (pt[6*k +: 6] == 6'd0) begin
                zero_seen = 1'b1;
                zc++;
            end else if (zero_seen) begin
                cyc = i;
                val = pt[6*k +: 6];
                break;
            end
        end
    endtask

    initial begin
        int             cyc;
        int             zc;
        logic [5:0]     val;
        logic [6*N-1:0] saved;
        logic [2:0]     codes [6];
        int             r;

        codes = '{3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};
        hs = {N{3'b101}};
        bus.cmd = 8'h00;
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pt", 32'(pt), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        rst = 1'b0;

        // Reset-cleared synchronisers read as an illegal code for two edges.
        repeat (4) step();
        chk("fault_post_rst", 32'(fault), 32'({N{1'b1}}));
        send(8'h08);
        chk("fault_clear_bcast", 32'(fault), 32'd0);
        repeat (2) step();

        // ch0 enable forward, hall 101 already settled
        send(8'h06);
        wait_pattern(0, 20, cyc, zc, val);
        chk("en_latency", 32'(cyc), 32'd9);
        chk("en_pattern", 32'(val), 32'b100010);

        // hall 101 -> 100: eight off cycles, then 100_001 at cycle 11
        set_hall(0, 3'b100);
        wait_pattern(0, 20, cyc, zc, val);
        chk("hall_latency", 32'(cyc), 32'd11);
        chk("hall_deadtime", 32'(zc), 32'(DT));
        chk("hall_pattern", 32'(val), 32'b100001);

        // hall 100 -> 101: 100_010 at cycle 11
        set_hall(0, 3'b101);
        wait_pattern(0, 20, cyc, zc, val);
        chk("settle_latency", 32'(cyc), 32'd11);
        chk("settle_pattern", 32'(val), 32'b100010);

        // toggled away and back inside dead-time restarts the count
        set_hall(0, 3'b100);
        repeat (5) step();
        set_hall(0, 3'b101);
        wait_pattern(0, 30, cyc, zc, val);
        chk("restart_latency", 32'(cyc), 32'd11);
        chk("restart_pattern", 32'(val), 32'b100010);

        // broadcast enable reverse
        send(8'h0C);
        wait_pattern(1, 20, cyc, zc, val);
        chk("rev_latency", 32'(cyc), 32'd9);
        chk("rev_pattern", 32'(val), 32'b010100);
        repeat (2) step();

        // broadcast brake
        send(8'h0D);
        for (int i = 1; i <= DT; i++) begin
            step();
            chk("brake_dt", 32'(pt), 32'd0);
        end
        step();
        chk("brake_all", 32'(pt), 32'({N{6'b000111}}));

        // illegal hall on ch2
        set_hall(2, 3'b111);
        repeat (3) step();
        chk("fault_not_yet", 32'(fault[2]), 32'd0);
        step();
        chk("fault_set", 32'(fault[2]), 32'd1);
        chk("fault_pt_prev", 32'(pt[17:12]), 32'b000111);
        step();
        chk("fault_pt_off", 32'(pt[17:12]), 32'd0);
        send(8'h26);
        repeat (2) step();
        chk("fault_kept_en", 32'(fault[2]), 32'd1);
        set_hall(2, 3'b101);
        repeat (3) step();
        send(8'h20);
        chk("fault_clear", 32'(fault[2]), 32'd0);
        repeat (3) step();
        chk("fault_stays_clear", 32'(fault[2]), 32'd0);

        // out-of-range index
        saved = pt;
        send(8'h56);
        chk("err_pulse", 32'(bus.cmd_err), 32'd1);
        chk("err_no_pt_change", 32'(pt), 32'(saved));
        step();
        chk("err_single", 32'(bus.cmd_err), 32'd0);

        // reset in the middle of ch0 dead-time while ch1/ch3 are braking
        send(8'h06);
        repeat (3) step();
        #2 rst = 1'b1;
        #1 chk("async_rst_pt", 32'(pt), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_hold_pt", 32'(pt), 32'd0);
        rst = 1'b0;
        repeat (20) step();
        chk("post_rst_off", 32'(pt), 32'd0);

        // randomized operation
        send(8'h08);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 15) == 0) begin
                    r = int'($urandom_range(0, 19));
                    if (r == 0) set_hall(k, 3'b000);
                    else if (r == 1) set_hall(k, 3'b111);
                    else set_hall(k, codes[$urandom_range(0, 5)]);
                end
            end
            if ($urandom_range(0, 24) == 0) send(8'($urandom));
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
